// File: rtl/fs_pkg.sv
// Shared definitions for the full subtractor: default width and the reference model
// used by the RTL assertion and the testbench.
package fs_pkg;

    localparam int unsigned FS_DEFAULT_WIDTH = 1;
    localparam int unsigned FS_MAX_W         = 64;

    // Returns {brw, dif} in bits [width:0]; all higher bits are zero.
    function automatic logic [FS_MAX_W:0] fs_ref(
        input logic [FS_MAX_W-1:0] a,
        input logic [FS_MAX_W-1:0] b,
        input logic                cin,
        input int unsigned         width
    );
        logic [FS_MAX_W:0] full;
        logic [FS_MAX_W:0] mask;
        full = {1'b0, a} - {1'b0, b} - {{FS_MAX_W{1'b0}}, cin};
        mask = ({{FS_MAX_W{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
        return full & mask;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: dif/brw hold a - b - cin one cycle after sampling.
module full_subtractor
    import fs_pkg::*;
#(
    parameter int unsigned WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] dif,
    output logic             brw
);

    logic [WIDTH:0]   bw;
    logic [WIDTH-1:0] d;

    assign bw[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fs_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bw[i]),
            .d    (d[i]),
            .bout (bw[i+1])
        );
    end

    // Stage p0 -> p1: output register, reset wins over fresh operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dif <= '0;
            brw <= 1'b0;
        end else begin
            dif <= d;
            brw <= bw[WIDTH];
        end
    end

    a_ref_match: assert property (@(posedge clk)
        $past(rst_n) |-> ((FS_MAX_W+1)'({brw, dif}) ==
            fs_ref(FS_MAX_W'($past(a)), FS_MAX_W'($past(b)), $past(cin), WIDTH)));

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor at WIDTH=1 and WIDTH=8.
module tb_full_subtractor;
    import fs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, cin1, dif1, brw1;
    logic [7:0] a8, b8, dif8;
    logic       cin8, brw8;

    int total  = 0;
    int passed = 0;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .dif(dif1), .brw(brw1)
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .dif(dif8), .brw(brw8)
    );

    always #5 clk = ~clk;

    // obs/exp are {brw, dif} zero-extended to 9 bits
    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {dif,brw} for {a,b,cin} = 0..7
        logic [1:0]        tbl [8];
        logic [2:0]        v;
        logic [FS_MAX_W:0] r;
        logic [8:0]        exp8;
        tbl[0] = 2'b00; tbl[1] = 2'b11; tbl[2] = 2'b11; tbl[3] = 2'b01;
        tbl[4] = 2'b10; tbl[5] = 2'b00; tbl[6] = 2'b00; tbl[7] = 2'b11;

        // Reset held for two edges with nonzero operands
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        a8 = 8'h01; b8 = 8'h00; cin8 = 1'b0;
        tick();
        chk("reset_e1_w1", {7'd0, brw1, dif1}, 9'h000);
        chk("reset_e1_w8", {brw8, dif8}, 9'h000);
        tick();
        chk("reset_e2_w1", {7'd0, brw1, dif1}, 9'h000);
        chk("reset_e2_w8", {brw8, dif8}, 9'h000);
        rst_n = 1'b1;
        tick();
        chk("release_w1", {7'd0, brw1, dif1}, 9'h001);
        chk("release_w8", {brw8, dif8}, 9'h001);

        // WIDTH=1 exhaustive sweep, back-to-back
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, cin1} = v;
            tick();
            chk($sformatf("sweep_%0d", i), {7'd0, brw1, dif1}, {7'd0, tbl[i][0], tbl[i][1]});
        end

        // Latency: result must not appear before the next edge
        {a1, b1, cin1} = 3'b110;
        tick();
        chk("lat_pre", {7'd0, brw1, dif1}, 9'h000);
        {a1, b1, cin1} = 3'b010;
        #3;
        chk("lat_before_edge", {7'd0, brw1, dif1}, 9'h000);
        tick();
        chk("lat_after_edge", {7'd0, brw1, dif1}, 9'h003);

        // Sweep again with a one-edge reset at index 4
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, cin1} = v;
            if (i == 4) begin
                rst_n = 1'b0;
                tick();
                chk("midreset", {7'd0, brw1, dif1}, 9'h000);
                rst_n = 1'b1;
            end
            tick();
            chk($sformatf("resume_%0d", i), {7'd0, brw1, dif1}, {7'd0, tbl[i][0], tbl[i][1]});
        end

        // WIDTH=8 boundaries
        a8 = 8'h00; b8 = 8'hFF; cin8 = 1'b1;
        tick();
        chk("w8_full_wrap", {brw8, dif8}, 9'h100);
        a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0;
        tick();
        chk("w8_80_minus_01", {brw8, dif8}, 9'h07F);
        a8 = 8'h5A; b8 = 8'h5A; cin8 = 1'b0;
        tick();
        chk("w8_eq_cin0", {brw8, dif8}, 9'h000);
        a8 = 8'h5A; b8 = 8'h5A; cin8 = 1'b1;
        tick();
        chk("w8_eq_cin1", {brw8, dif8}, 9'h1FF);
        a8 = 8'h10; b8 = 8'h03; cin8 = 1'b1;
        tick();
        chk("w8_10_03_1", {brw8, dif8}, 9'h00C);

        // WIDTH=8 random, back-to-back
        for (int i = 0; i < 1000; i++) begin
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            cin8 = 1'($urandom_range(0, 1));
            r    = fs_ref(FS_MAX_W'(a8), FS_MAX_W'(b8), cin8, 8);
            exp8 = r[8:0];
            tick();
            chk($sformatf("w8_rand_%0d", i), {brw8, dif8}, exp8);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
